// File: rtl/fsm_trace_monitor_if.sv
// ============================================================================
//  Module   : fsm_trace_monitor_if
//  Brief    : Observation bus between the q_5_9 sequence FSM side (master)
//             and the fsm_trace_monitor (slave).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fsm_trace_monitor_if #(
    parameter int CNT_W = 8
) ();
    logic             en;
    logic [1:0]       state_in;
    logic             x_in;
    logic             clr_err;
    logic [1:0]       rd_sel;
    logic [CNT_W-1:0] rd_cnt;
    logic             trans_pulse;
    logic [CNT_W-1:0] dwell_cnt;
    logic [CNT_W-1:0] max_dwell;
    logic             seq_hit;
    logic             illegal;
    logic [1:0]       err_state;
    logic [1:0]       err_prev;

    modport master (
        output en, state_in, x_in, clr_err, rd_sel,
        input  rd_cnt, trans_pulse, dwell_cnt, max_dwell, seq_hit,
               illegal, err_state, err_prev
    );

    modport slave (
        input  en, state_in, x_in, clr_err, rd_sel,
        output rd_cnt, trans_pulse, dwell_cnt, max_dwell, seq_hit,
               illegal, err_state, err_prev
    );
endinterface

`default_nettype wire

// File: rtl/fsm_trace_monitor.sv
// ============================================================================
//  Module   : fsm_trace_monitor
//  Brief    : Trace/health monitor for the q_5_9 FSM state code: transition
//             pulses, visit counts, dwell tracking, S0-S3-S1-S2 detector.
//             Optional macro TRANS_CHECK_EN builds the transition checker.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_trace_monitor #(
    parameter int CNT_W = 8
) (
    input  wire logic            clk,
    input  wire logic            rstn,
    fsm_trace_monitor_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       c_SEQ = 8'b00_11_01_10;

    logic [1:0]       r_prev_state;
    logic             r_prev_x;
    logic             r_primed;
    logic [CNT_W-1:0] r_dwell;
    logic [CNT_W-1:0] r_max;
    logic [CNT_W-1:0] r_visit [4];
    logic [7:0]       r_hist;
    logic             r_trans;
    logic             r_seq;

    logic             w_entry;
    logic [CNT_W-1:0] w_dwell_nxt;
    logic [7:0]       w_hist_nxt;
    logic             w_seq;

    always_comb begin
        w_entry     = !r_primed || (bus.state_in != r_prev_state);
        w_dwell_nxt = r_dwell;
        if (w_entry) begin
            w_dwell_nxt = c_ONE;
        end else if (r_dwell != c_SAT) begin
            w_dwell_nxt = r_dwell + c_ONE;
        end
        // History is oldest-to-newest from MSB to LSB
        w_hist_nxt = {r_hist[5:0], bus.state_in};
        w_seq      = w_entry && (bus.state_in == 2'b10) && (w_hist_nxt == c_SEQ);
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_prev_state <= 2'b00;
            r_prev_x     <= 1'b0;
            r_primed     <= 1'b0;
            r_dwell      <= '0;
            r_max        <= '0;
            r_hist       <= 8'h00;
            r_trans      <= 1'b0;
            r_seq        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_visit[i] <= '0;
            end
        end else if (bus.en) begin
            r_prev_state <= bus.state_in;
            r_prev_x     <= bus.x_in;
            r_primed     <= 1'b1;
            r_trans      <= r_primed && (bus.state_in != r_prev_state);
            r_seq        <= w_seq;
            r_dwell      <= w_dwell_nxt;
            if (w_dwell_nxt > r_max) begin
                r_max <= w_dwell_nxt;
            end
            if (w_entry) begin
                r_hist <= w_hist_nxt;
            end
            for (int i = 0; i < 4; i++) begin
                if (w_entry && (bus.state_in == 2'(i)) && (r_visit[i] != c_SAT)) begin
                    r_visit[i] <= r_visit[i] + c_ONE;
                end
            end
        end else begin
            r_trans <= 1'b0;
            r_seq   <= 1'b0;
        end
    end

    assign bus.rd_cnt      = r_visit[bus.rd_sel];
    assign bus.trans_pulse = r_trans;
    assign bus.dwell_cnt   = r_dwell;
    assign bus.max_dwell   = r_max;
    assign bus.seq_hit     = r_seq;

`ifdef TRANS_CHECK_EN
    logic [1:0] w_expect;
    logic       w_bad;
    logic       r_illegal;
    logic [1:0] r_err_state;
    logic [1:0] r_err_prev;

    // Next-state table of the q_5_9 FSM, indexed by the previous sample
    always_comb begin
        w_expect = 2'b00;
        case (r_prev_state)
            2'b00:   w_expect = r_prev_x ? 2'b11 : 2'b00;
            2'b01:   w_expect = r_prev_x ? 2'b10 : 2'b00;
            2'b10:   w_expect = r_prev_x ? 2'b11 : 2'b10;
            default: w_expect = 2'b01;
        endcase
        w_bad = r_primed && (bus.state_in != w_expect);
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_illegal   <= 1'b0;
            r_err_state <= 2'b00;
            r_err_prev  <= 2'b00;
        end else if (bus.en) begin
            if (w_bad) begin
                r_illegal <= 1'b1;
                // A clear on the same edge releases the capture for the new error
                if (!r_illegal || bus.clr_err) begin
                    r_err_state <= bus.state_in;
                    r_err_prev  <= r_prev_state;
                end
            end else if (bus.clr_err) begin
                r_illegal   <= 1'b0;
                r_err_state <= 2'b00;
                r_err_prev  <= 2'b00;
            end
        end
    end

    assign bus.illegal   = r_illegal;
    assign bus.err_state = r_err_state;
    assign bus.err_prev  = r_err_prev;
`else
    logic w_unused_chk;
    assign w_unused_chk  = ^{bus.clr_err, r_prev_x};
    assign bus.illegal   = 1'b0;
    assign bus.err_state = 2'b00;
    assign bus.err_prev  = 2'b00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fsm_trace_monitor.sv
// ============================================================================
//  Module   : tb_fsm_trace_monitor
//  Brief    : Directed, table-driven self-checking bench for fsm_trace_monitor.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsm_trace_monitor;

    localparam int W = 4;
`ifdef TRANS_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] st;
        logic       x;
        logic       clr;
        logic       tp;
        logic       sh;
        logic [3:0] dw;
        logic [3:0] mx;
        logic       ill;
        logic [1:0] es;
        logic [1:0] ep;
        logic [15:0] vis;   // {v3,v2,v1,v0}
    } vec_t;

    logic clk = 1'b0;
    logic rstn;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fsm_trace_monitor_if #(.CNT_W(W)) bus ();

    fsm_trace_monitor #(.CNT_W(W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic e, input logic [1:0] s,
                         input logic xv, input logic c);
        rstn         = r;
        bus.en       = e;
        bus.state_in = s;
        bus.x_in     = xv;
        bus.clr_err  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vis(input string tag, input logic [15:0] v);
        for (int i = 0; i < 4; i++) begin
            bus.rd_sel = 2'(i);
            #1;
            chk($sformatf("%s visit[%0d]", tag, i), 16'(bus.rd_cnt), 16'(v[i*4 +: 4]));
        end
    endtask

    vec_t tbl[$];

    initial begin
        int tp_seen;
        int n_en;
        rstn = 1'b1; bus.en = 1'b0; bus.state_in = 2'b00; bus.x_in = 1'b0;
        bus.clr_err = 1'b0; bus.rd_sel = 2'b00;

        //              rst  en  st     x    clr  tp   sh   dw  mx  ill  es     ep     vis
        // Legal walk with S0-S3-S1-S2 entry sequence
        tbl.push_back('{1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,1'b0,2'b00,2'b00,16'h0000});
        tbl.push_back('{1'b0,1'b1,2'b00,1'b1,1'b0,1'b0,1'b0,4'd1,4'd1,1'b0,2'b00,2'b00,16'h0001});
        tbl.push_back('{1'b0,1'b1,2'b11,1'b1,1'b0,1'b1,1'b0,4'd1,4'd1,1'b0,2'b00,2'b00,16'h1001});
        tbl.push_back('{1'b0,1'b1,2'b01,1'b1,1'b0,1'b1,1'b0,4'd1,4'd1,1'b0,2'b00,2'b00,16'h1011});
        tbl.push_back('{1'b0,1'b1,2'b10,1'b0,1'b0,1'b1,1'b1,4'd1,4'd1,1'b0,2'b00,2'b00,16'h1111});
        tbl.push_back('{1'b0,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,4'd2,4'd2,1'b0,2'b00,2'b00,16'h1111});
        // Reset mid-run, then a single sample
        tbl.push_back('{1'b1,1'b1,2'b01,1'b1,1'b0,1'b0,1'b0,4'd0,4'd0,1'b0,2'b00,2'b00,16'h0000});
        tbl.push_back('{1'b0,1'b1,2'b01,1'b1,1'b0,1'b0,1'b0,4'd1,4'd1,1'b0,2'b00,2'b00,16'h0010});
        // Illegal transitions, sticky capture, clear/error collision, clear
        tbl.push_back('{1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,1'b0,2'b00,2'b00,16'h0000});
        tbl.push_back('{1'b0,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,4'd1,4'd1,1'b0,2'b00,2'b00,16'h0001});
        tbl.push_back('{1'b0,1'b1,2'b01,1'b0,1'b0,1'b1,1'b0,4'd1,4'd1,1'b1,2'b01,2'b00,16'h0011});
        tbl.push_back('{1'b0,1'b1,2'b11,1'b0,1'b0,1'b1,1'b0,4'd1,4'd1,1'b1,2'b01,2'b00,16'h1011});
        tbl.push_back('{1'b0,1'b1,2'b01,1'b1,1'b0,1'b1,1'b0,4'd1,4'd1,1'b1,2'b01,2'b00,16'h1021});
        tbl.push_back('{1'b0,1'b1,2'b10,1'b1,1'b0,1'b1,1'b0,4'd1,4'd1,1'b1,2'b01,2'b00,16'h1121});
        tbl.push_back('{1'b0,1'b0,2'b11,1'b1,1'b1,1'b0,1'b0,4'd1,4'd1,1'b1,2'b01,2'b00,16'h1121});
        tbl.push_back('{1'b0,1'b1,2'b00,1'b0,1'b1,1'b1,1'b0,4'd1,4'd1,1'b1,2'b00,2'b10,16'h1122});
        tbl.push_back('{1'b0,1'b1,2'b00,1'b0,1'b1,1'b0,1'b0,4'd2,4'd2,1'b0,2'b00,2'b00,16'h1122});
        tbl.push_back('{1'b0,1'b0,2'b11,1'b0,1'b0,1'b0,1'b0,4'd2,4'd2,1'b0,2'b00,2'b00,16'h1122});

        for (int k = 0; k < tbl.size(); k++) begin
            string t;
            t = $sformatf("vec%0d", k);
            apply(tbl[k].rst, tbl[k].en, tbl[k].st, tbl[k].x, tbl[k].clr);
            chk({t, " trans_pulse"}, 16'(bus.trans_pulse), 16'(tbl[k].tp));
            chk({t, " seq_hit"},     16'(bus.seq_hit),     16'(tbl[k].sh));
            chk({t, " dwell_cnt"},   16'(bus.dwell_cnt),   16'(tbl[k].dw));
            chk({t, " max_dwell"},   16'(bus.max_dwell),   16'(tbl[k].mx));
            chk({t, " illegal"},     16'(bus.illegal),     16'(CHK ? tbl[k].ill : 1'b0));
            chk({t, " err_state"},   16'(bus.err_state),   16'(CHK ? tbl[k].es : 2'b00));
            chk({t, " err_prev"},    16'(bus.err_prev),    16'(CHK ? tbl[k].ep : 2'b00));
            check_vis(t, tbl[k].vis);
        end

        // Saturation: 40 samples parked in S2
        apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        tp_seen = 0;
        for (int k = 0; k < 40; k++) begin
            apply(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
            if (bus.trans_pulse !== 1'b0) tp_seen++;
        end
        chk("sat dwell_cnt", 16'(bus.dwell_cnt), 16'd15);
        chk("sat max_dwell", 16'(bus.max_dwell), 16'd15);
        chk("sat trans_pulse count", 16'(tp_seen), 16'd0);
        bus.rd_sel = 2'b10;
        #1;
        chk("sat visit[2]", 16'(bus.rd_cnt), 16'd1);
        chk("sat illegal", 16'(bus.illegal), 16'd0);

        // Enable gating: state toggles every cycle, only en=1 cycles sample S0
        apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        n_en = 0;
        for (int k = 0; k < 8; k++) begin
            logic e;
            e = (k % 2 == 0);
            apply(1'b0, e, (k % 2 == 0) ? 2'b00 : 2'b11, 1'b0, 1'b0);
            if (e) n_en++;
            chk($sformatf("gate%0d trans_pulse", k), 16'(bus.trans_pulse), 16'd0);
            chk($sformatf("gate%0d dwell_cnt", k), 16'(bus.dwell_cnt), 16'(n_en));
        end
        chk("gate max_dwell", 16'(bus.max_dwell), 16'd4);
        check_vis("gate", 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fsm_trace_monitor.md
Name: fsm_trace_monitor

Overview:
- Downstream consumer of the 2-bit state code driven by the q_5_9 sequence FSM (states S0=00, S1=01, S2=10, S3=11).
- Observes the state code together with the FSM's stimulus bit x_in, and produces:
  - transition pulses;
  - per-state visit counts;
  - a current and a maximum dwell length;
  - a detector for the entry sequence S0→S3→S1→S2.
- Sits beside the FSM in the bench and in integration. Used as a run-time trace and health monitor.

Parameters:
- CNT_W, 8, width of the dwell counter, the max-dwell counter and each visit counter. Legal range 2..16.

Ports:
- clk  input  1  rising-edge clock, shared with the FSM.
- rstn  input  1  synchronous reset, active-high. rstn=1 at a rising edge resets the block.
- en  input  1  sample enable. State and x_in are sampled only on edges where en=1.
- state_in  input  2  state code from the FSM.
- x_in  input  1  stimulus bit applied to the FSM in the same cycle.
- clr_err  input  1  clears the sticky error (used only with TRANS_CHECK_EN).
- rd_sel  input  2  selects which visit counter appears on rd_cnt.
- rd_cnt  output  CNT_W  visit count of state rd_sel. Combinational mux of registers.
- trans_pulse  output  1  one-cycle pulse: the latest sample differs from the previous one.
- dwell_cnt  output  CNT_W  consecutive samples spent in the current state, including the latest.
- max_dwell  output  CNT_W  largest dwell_cnt seen since reset.
- seq_hit  output  1  one-cycle pulse: the last four state entries were S0, S3, S1, S2 in that order.
- illegal  output  1  sticky error: a transition violated the FSM table.
- err_state  output  2  state_in captured at the first illegal transition.
- err_prev  output  2  previous state captured at the first illegal transition.

Behaviour:
- All outputs are registered except rd_cnt. Each register updates on the sampling edge and is visible right after that edge, so latency is 1 cycle.
- Reset (rstn=1 at an edge):
  - prev_state=00, prev_x=0, primed=0;
  - all counters=0, entry history=0;
  - trans_pulse=0, seq_hit=0, illegal=0, err_state=00, err_prev=00.
  - Reset has priority over all other inputs, including in the middle of a run.
- en=0: every register holds its value; trans_pulse and seq_hit are driven 0.
- Sample with en=1: define "entry" as (primed=0) OR (state_in != prev_state).
  - prev_state<=state_in; prev_x<=x_in; primed<=1.
  - trans_pulse<=primed AND (state_in != prev_state). The first sample after reset never pulses.
  - dwell_cnt<=1 on entry. Otherwise dwell_cnt increments, saturating at 2^CNT_W-1.
  - max_dwell<=max(max_dwell, next dwell_cnt).
  - On entry: visit_cnt[state_in] increments, saturating at 2^CNT_W-1. Entry history (4 x 2 bits) shifts in state_in.
  - seq_hit<=1 when the entry is S2 and the history after the shift, oldest to newest, is 00,11,01,10. Overlapping occurrences each fire.
- Transition check (primed=1 only). Expected next state from (prev_state, prev_x):
  - S0: x=0→S0, x=1→S3;
  - S1: x=0→S0, x=1→S2;
  - S2: x=0→S2, x=1→S3;
  - S3: any x→S1.
  - If state_in != expected: illegal<=1. If illegal was 0, also err_state<=state_in and err_prev<=prev_state.
  - Later errors do not overwrite the captured values.
- clr_err=1 clears illegal, err_state and err_prev. If clr_err and a new error occur on the same edge, the error wins and captures the new values.
- Saturated counters stay saturated until reset.

Optional Feature:
- TRANS_CHECK_EN defined: the transition checker, illegal, err_state, err_prev and clr_err operate as above.
- TRANS_CHECK_EN undefined: checker logic is not built; illegal=0, err_state=00, err_prev=00 constantly; clr_err is ignored. All other behaviour is unchanged.

Test Plan:
- Legal walk:
  - Stimulus: reset, en=1, (state_in,x_in) = (00,1),(11,1),(01,1),(10,0),(10,0).
  - Required: trans_pulse high after samples 2, 3 and 4. seq_hit pulses once, after sample 4. Visit counts for 00/11/01/10 = 1/1/1/1. dwell_cnt=2 and max_dwell=2 at the end. illegal=0.
- Illegal transition (TRANS_CHECK_EN):
  - Stimulus: (00,0) then (01,0) then (11,x).
  - Required: illegal=1, err_state=01, err_prev=00 after sample 2. These values are unchanged after the further error at sample 3. clr_err pulse then returns illegal to 0.
- Saturation:
  - Stimulus: CNT_W=4, state_in=10, x_in=0 for 40 samples.
  - Required: dwell_cnt=15, max_dwell=15, rd_sel=10 gives rd_cnt=1, no trans_pulse.
- Enable gating:
  - Stimulus: alternate en with state_in toggling 00/11 on every cycle.
  - Required: only the en=1 samples count. trans_pulse is never high in an en=0 cycle.
- Reset mid-run:
  - Stimulus: after the legal walk, assert rstn=1 for 1 edge, then sample (01,1).
  - Required: all counters clear. After that sample: dwell_cnt=1, visit_cnt[01]=1, no trans_pulse, no illegal.
- Simultaneous clear and error:
  - Stimulus: with illegal=1, assert clr_err on the same edge as a new bad transition 10→00 with prev_x=1.
  - Required: illegal=1, err_state=00, err_prev=10.
